// File: rtl/rf_mp_if.sv
// ---------------------------------------------------------------------------
// rf_mp_if -- bus bundle for the multi-read-port register file rf_mp.
//
// Parameters (must match the rf_mp instance it is connected to):
//   DW : data width in bits
//   AW : address width, depth = 2**AW
//   NR : number of read ports
//
// Signals:
//   raddr [NR*AW] : read addresses, port k at [k*AW +: AW]
//   rdata [NR*DW] : read data,      port k at [k*DW +: DW]
//   rbusy [NR]    : pending bit of the register addressed by each read port
//   we, waddr, wdata : writeback port (write + pending clear)
//   pset, paddr      : decode-side pending set
//
// Modports:
//   master : decode/writeback side driving requests
//   slave  : the register file
// ---------------------------------------------------------------------------
interface rf_mp_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
);
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic             pset;
    logic [AW-1:0]    paddr;

    modport master (
        output raddr, we, waddr, wdata, pset, paddr,
        input  rdata, rbusy
    );

    modport slave (
        input  raddr, we, waddr, wdata, pset, paddr,
        output rdata, rbusy
    );
endinterface

// File: rtl/rf_mp.sv
// ---------------------------------------------------------------------------
// rf_mp -- parametrised multi-read-port register file with a per-register
// pending scoreboard, placed between decode (reads, pending set) and
// writeback (write, pending clear).
//
// Parameters:
//   DW : data width in bits (default 32)
//   AW : address width, depth = 2**AW registers (default 5)
//   NR : number of read ports, 1..4 (default 2)
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; clears all registers and all
//           pending bits, and overrides any write/set on the same edge
//   bus   : rf_mp_if.slave
//           - raddr/rdata/rbusy : NR combinational read ports
//           - we/waddr/wdata    : write, also clears pend[waddr]
//           - pset/paddr        : marks pend[paddr] (producer issued)
//
// Behaviour:
//   - Register 0 is hardwired to zero: writes to it are dropped and its
//     pending bit never sets.
//   - Same-edge pending set and clear on one address: set wins.
//
// Configuration macro:
//   RF_BYPASS_EN -- when defined, a read port whose address matches an
//   active non-zero write returns wdata and rbusy=0 in the same cycle.
//   When undefined, read-during-write returns the old stored value and
//   the registered pending bit.
// ---------------------------------------------------------------------------
module rf_mp #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    rf_mp_if.slave   bus
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] pend;

    // -----------------------------------------------------------------------
    // Storage. Every word is cleared by the synchronous reset, so r0 is 0
    // from reset onwards and, since it is never written, stays 0.
    // -----------------------------------------------------------------------
    // NOTE: the memory is inside the reset branch on purpose: the register
    // file must read 0 everywhere after reset, which rules out a RAM macro
    // without a clear port. Non-blocking assignments keep every read in this
    // cycle seeing the pre-edge contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.we && (bus.waddr != '0)) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Pending scoreboard. The clear is written before the set, so when both
    // target the same bit the later non-blocking assignment (the set) is
    // the one that lands: a new producer has issued for that register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            if (bus.we) begin
                pend[bus.waddr] <= 1'b0;
            end
            if (bus.pset && (bus.paddr != '0)) begin
                pend[bus.paddr] <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read ports: purely combinational, independent per port.
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;

        assign ra = bus.raddr[k*AW +: AW];

`ifdef RF_BYPASS_EN
        // The producer is completing this cycle, so the reader sees the
        // new value and is not stalled, regardless of a same-cycle pset.
        assign hit = bus.we && (bus.waddr == ra) && (bus.waddr != '0);
`else
        assign hit = 1'b0;
`endif

        assign bus.rdata[k*DW +: DW] = hit ? bus.wdata : mem[ra];
        assign bus.rbusy[k]          = hit ? 1'b0      : pend[ra];
    end

endmodule

// File: tb/tb_rf_mp.sv
// ---------------------------------------------------------------------------
// tb_rf_mp -- directed testbench for rf_mp.
// Instance dut_a uses the default parameters (DW=32, AW=5, NR=2);
// instance dut_b uses DW=16, AW=5, NR=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled a
// further time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_rf_mp;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_a_n = 1'b1;
    logic rst_b_n = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_mp_if #(.DW(32), .AW(5), .NR(2)) if_a ();
    rf_mp_if #(.DW(16), .AW(5), .NR(3)) if_b ();

    rf_mp #(.DW(32), .AW(5), .NR(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_a_n),
        .bus   (if_a.slave)
    );

    rf_mp #(.DW(16), .AW(5), .NR(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .bus   (if_b.slave)
    );

    // Advance past one rising edge; inputs may be changed right after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        if_a.we    = 1'b0;
        if_a.waddr = '0;
        if_a.wdata = '0;
        if_a.pset  = 1'b0;
        if_a.paddr = '0;
    endtask

    task automatic idle_b();
        if_b.we    = 1'b0;
        if_b.waddr = '0;
        if_b.wdata = '0;
        if_b.pset  = 1'b0;
        if_b.paddr = '0;
    endtask

    function automatic logic [31:0] rd_a(input int k);
        return if_a.rdata[k*32 +: 32];
    endfunction

    function automatic logic [15:0] rd_b(input int k);
        return if_b.rdata[k*16 +: 16];
    endfunction

    // -----------------------------------------------------------------------
    // Reset both instances with a write/set pending on the reset edge, then
    // sweep every address on every port.
    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst_a_n    = 1'b0;
        rst_b_n    = 1'b0;
        if_a.we    = 1'b1;
        if_a.waddr = 5'd3;
        if_a.wdata = 32'h1234_5678;
        if_a.pset  = 1'b1;
        if_a.paddr = 5'd4;
        tick();
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        idle_a();
        idle_b();
        for (int a = 0; a < 32; a++) begin
            if_a.raddr = {a[4:0], a[4:0]};
            if_b.raddr = {a[4:0], a[4:0], a[4:0]};
            #1;
            n_tests++;
            if (if_a.rdata !== 64'h0 || if_a.rbusy !== 2'b00) begin
                $display("FAIL reset_a addr %0d: rdata=%h rbusy=%b, expected 0/00",
                         a, if_a.rdata, if_a.rbusy);
                n_fail++;
            end
            n_tests++;
            if (if_b.rdata !== 48'h0 || if_b.rbusy !== 3'b000) begin
                $display("FAIL reset_b addr %0d: rdata=%h rbusy=%b, expected 0/000",
                         a, if_b.rdata, if_b.rbusy);
                n_fail++;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Two writes, read back on both ports; a write to r0 is discarded.
    // -----------------------------------------------------------------------
    task automatic test_write_read();
        if_a.we    = 1'b1;
        if_a.waddr = 5'd16;
        if_a.wdata = 32'd1337;
        tick();
        if_a.waddr = 5'd9;
        if_a.wdata = 32'd69;
        tick();
        idle_a();
        if_a.raddr = {5'd9, 5'd16};
        #1;
        n_tests++;
        if (rd_a(0) !== 32'd1337) begin
            $display("FAIL wr_r16_p0: got %0d expected 1337", rd_a(0));
            n_fail++;
        end
        n_tests++;
        if (rd_a(1) !== 32'd69) begin
            $display("FAIL wr_r9_p1: got %0d expected 69", rd_a(1));
            n_fail++;
        end
        // Swap ports to show both ports reach both registers.
        if_a.raddr = {5'd16, 5'd9};
        #1;
        n_tests++;
        if (if_a.rdata !== {32'd1337, 32'd69}) begin
            $display("FAIL wr_swap: got %h expected %h", if_a.rdata, {32'd1337, 32'd69});
            n_fail++;
        end

        if_a.we    = 1'b1;
        if_a.waddr = 5'd0;
        if_a.wdata = 32'hDEAD_BEEF;
        tick();
        idle_a();
        if_a.raddr = {5'd0, 5'd0};
        #1;
        n_tests++;
        if (if_a.rdata !== 64'h0 || if_a.rbusy !== 2'b00) begin
            $display("FAIL wr_r0: rdata=%h rbusy=%b expected 0/00", if_a.rdata, if_a.rbusy);
            n_fail++;
        end
    endtask

    // -----------------------------------------------------------------------
    // Read-during-write on r5 (old value 7, pending), other port on r16.
    // -----------------------------------------------------------------------
    task automatic test_rdw();
        // r5 = 7 and pend[5] set on the same edge (set wins).
        if_a.we    = 1'b1;
        if_a.waddr = 5'd5;
        if_a.wdata = 32'd7;
        if_a.pset  = 1'b1;
        if_a.paddr = 5'd5;
        tick();
        idle_a();
        if_a.raddr = {5'd16, 5'd5};
        #1;
        n_tests++;
        if (rd_a(0) !== 32'd7 || if_a.rbusy !== 2'b01) begin
            $display("FAIL rdw_setup: rdata0=%0d rbusy=%b expected 7/01", rd_a(0), if_a.rbusy);
            n_fail++;
        end

        if_a.we    = 1'b1;
        if_a.waddr = 5'd5;
        if_a.wdata = 32'hA5A5_A5A5;
        #1;
        n_tests++;
        if (rd_a(0) !== (BYP ? 32'hA5A5_A5A5 : 32'd7)) begin
            $display("FAIL rdw_same_cycle: got %h expected %h",
                     rd_a(0), BYP ? 32'hA5A5_A5A5 : 32'd7);
            n_fail++;
        end
        n_tests++;
        if (if_a.rbusy[0] !== ~BYP) begin
            $display("FAIL rdw_busy_same_cycle: got %b expected %b", if_a.rbusy[0], ~BYP);
            n_fail++;
        end
        n_tests++;
        if (rd_a(1) !== 32'd1337 || if_a.rbusy[1] !== 1'b0) begin
            $display("FAIL rdw_other_port: got %0d/%b expected 1337/0", rd_a(1), if_a.rbusy[1]);
            n_fail++;
        end
        tick();
        idle_a();
        #1;
        n_tests++;
        if (rd_a(0) !== 32'hA5A5_A5A5 || if_a.rbusy[0] !== 1'b0) begin
            $display("FAIL rdw_next_cycle: got %h/%b expected a5a5a5a5/0", rd_a(0), if_a.rbusy[0]);
            n_fail++;
        end
    endtask

    // -----------------------------------------------------------------------
    // Pending set, visibility timing, clear by write, pset on r0.
    // -----------------------------------------------------------------------
    task automatic test_scoreboard();
        if_a.raddr = {5'd0, 5'd12};
        if_a.pset  = 1'b1;
        if_a.paddr = 5'd12;
        #1;
        n_tests++;
        if (if_a.rbusy[0] !== 1'b0) begin
            $display("FAIL sb_same_cycle_invisible: got %b expected 0", if_a.rbusy[0]);
            n_fail++;
        end
        tick();
        idle_a();
        #1;
        n_tests++;
        if (if_a.rbusy[0] !== 1'b1) begin
            $display("FAIL sb_set_r12: got %b expected 1", if_a.rbusy[0]);
            n_fail++;
        end

        if_a.we    = 1'b1;
        if_a.waddr = 5'd12;
        if_a.wdata = 32'd42;
        tick();
        idle_a();
        #1;
        n_tests++;
        if (if_a.rbusy[0] !== 1'b0 || rd_a(0) !== 32'd42) begin
            $display("FAIL sb_clear_r12: rbusy=%b rdata=%0d expected 0/42", if_a.rbusy[0], rd_a(0));
            n_fail++;
        end

        if_a.pset  = 1'b1;
        if_a.paddr = 5'd0;
        tick();
        idle_a();
        if_a.raddr = {5'd0, 5'd0};
        #1;
        n_tests++;
        if (if_a.rbusy !== 2'b00 || if_a.rdata !== 64'h0) begin
            $display("FAIL sb_pset_r0: rbusy=%b rdata=%h expected 00/0", if_a.rbusy, if_a.rdata);
            n_fail++;
        end
    endtask

    // -----------------------------------------------------------------------
    // Same-edge set and clear: same address (set wins), different addresses.
    // -----------------------------------------------------------------------
    task automatic test_set_clear();
        if_a.pset  = 1'b1;
        if_a.paddr = 5'd3;
        tick();
        if_a.we    = 1'b1;
        if_a.waddr = 5'd3;
        if_a.wdata = 32'd11;
        tick();
        idle_a();
        if_a.raddr = {5'd4, 5'd3};
        #1;
        n_tests++;
        if (if_a.rbusy !== 2'b01 || rd_a(0) !== 32'd11) begin
            $display("FAIL sc_same_addr: rbusy=%b r3=%0d expected 01/11", if_a.rbusy, rd_a(0));
            n_fail++;
        end

        if_a.pset  = 1'b1;
        if_a.paddr = 5'd4;
        if_a.we    = 1'b1;
        if_a.waddr = 5'd3;
        if_a.wdata = 32'd11;
        tick();
        idle_a();
        #1;
        n_tests++;
        if (if_a.rbusy !== 2'b10) begin
            $display("FAIL sc_diff_addr: rbusy=%b expected 10", if_a.rbusy);
            n_fail++;
        end
    endtask

    // -----------------------------------------------------------------------
    // Reset asserted together with a write and a set on the default instance.
    // -----------------------------------------------------------------------
    task automatic test_reset_mid_a();
        if_a.we    = 1'b1;
        if_a.waddr = 5'd7;
        if_a.wdata = 32'd99;
        if_a.pset  = 1'b1;
        if_a.paddr = 5'd8;
        tick();
        idle_a();
        if_a.raddr = {5'd8, 5'd7};
        #1;
        n_tests++;
        if (rd_a(0) !== 32'd99 || if_a.rbusy !== 2'b10) begin
            $display("FAIL rm_a_setup: r7=%0d rbusy=%b expected 99/10", rd_a(0), if_a.rbusy);
            n_fail++;
        end

        rst_a_n    = 1'b0;
        if_a.we    = 1'b1;
        if_a.waddr = 5'd7;
        if_a.wdata = 32'd5;
        if_a.pset  = 1'b1;
        if_a.paddr = 5'd9;
        tick();
        rst_a_n = 1'b1;
        idle_a();
        #1;
        n_tests++;
        if (if_a.rdata !== 64'h0 || if_a.rbusy !== 2'b00) begin
            $display("FAIL rm_a_after: rdata=%h rbusy=%b expected 0/00", if_a.rdata, if_a.rbusy);
            n_fail++;
        end
        if_a.raddr = {5'd9, 5'd16};
        #1;
        n_tests++;
        if (rd_a(0) !== 32'd0 || if_a.rbusy[1] !== 1'b0) begin
            $display("FAIL rm_a_others: r16=%0d pend9=%b expected 0/0", rd_a(0), if_a.rbusy[1]);
            n_fail++;
        end
    endtask

    // -----------------------------------------------------------------------
    // Same scenario on the DW=16 / NR=3 instance.
    // -----------------------------------------------------------------------
    task automatic test_param_b();
        if_b.we    = 1'b1;
        if_b.waddr = 5'd7;
        if_b.wdata = 16'd99;
        if_b.pset  = 1'b1;
        if_b.paddr = 5'd8;
        tick();
        if_b.waddr = 5'd2;
        if_b.wdata = 16'hBEEF;
        if_b.pset  = 1'b0;
        tick();
        idle_b();
        if_b.raddr = {5'd7, 5'd2, 5'd8};
        #1;
        n_tests++;
        if (if_b.rdata !== {16'd99, 16'hBEEF, 16'h0} || if_b.rbusy !== 3'b001) begin
            $display("FAIL pb_read3: rdata=%h rbusy=%b expected 0063beef0000/001",
                     if_b.rdata, if_b.rbusy);
            n_fail++;
        end
        if_b.raddr = {5'd2, 5'd2, 5'd2};
        #1;
        n_tests++;
        if (rd_b(0) !== 16'hBEEF || rd_b(1) !== 16'hBEEF || rd_b(2) !== 16'hBEEF) begin
            $display("FAIL pb_same_addr: rdata=%h expected beefbeefbeef", if_b.rdata);
            n_fail++;
        end

        if_b.raddr = {5'd2, 5'd8, 5'd7};
        rst_b_n    = 1'b0;
        if_b.we    = 1'b1;
        if_b.waddr = 5'd7;
        if_b.wdata = 16'd5;
        tick();
        rst_b_n = 1'b1;
        idle_b();
        #1;
        n_tests++;
        if (if_b.rdata !== 48'h0 || if_b.rbusy !== 3'b000) begin
            $display("FAIL pb_reset_mid: rdata=%h rbusy=%b expected 0/000", if_b.rdata, if_b.rbusy);
            n_fail++;
        end
    endtask

    initial begin
        idle_a();
        idle_b();
        if_a.raddr = '0;
        if_b.raddr = '0;
        tick();
        test_reset();
        test_write_read();
        test_rdw();
        test_scoreboard();
        test_set_clear();
        test_reset_mid_a();
        test_param_b();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_mp.md
# rf_mp

Parametrised multi-read-port register file for the MIPS datapath, successor to the fixed 32x32 two-read/one-write `rf`. It adds:
- configurable data width, depth and read-port count;
- synchronous clear;
- a hardwired zero register;
- a per-register pending scoreboard, so decode can stall on in-flight producers;
- optional write-to-read bypass.

It sits between decode (reads, pending set) and writeback (write, pending clear).

## Interface
Parameters:
- `DW`, 32, data width in bits
- `AW`, 5, address width; depth = 2**AW registers
- `NR`, 2, number of read ports (1..4)

Ports:
- `clk`  in  1  clock. One clock; everything is rising-edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `raddr`  in  NR*AW  read addresses. Port k occupies bits [k*AW +: AW].
- `rdata`  out  NR*DW  read data. Port k occupies bits [k*DW +: DW]. Combinational.
- `rbusy`  out  NR  per-port flag: the pending bit of `raddr` port k is set. Combinational.
- `we`  in  1  write enable.
- `waddr`  in  AW  write address.
- `wdata`  in  DW  write data.
- `pset`  in  1  mark register `paddr` pending (producer issued).
- `paddr`  in  AW  pending-set address.

## Operation
- Storage is 2**AW words of DW bits. Register 0 always reads 0.
- Write: a rising edge with `we`=1 and `waddr`!=0 stores `wdata` at `waddr`. Writes to address 0 are discarded.
- Read: `rdata` port k = mem[`raddr` port k]. All ports read independently. Any ports may read the same address.
- Pending scoreboard holds one bit per register; bit 0 is always 0.
  - A rising edge with `pset`=1 and `paddr`!=0 sets pend[`paddr`].
  - A rising edge with `we`=1 clears pend[`waddr`].
  - If set and clear hit the same address on the same edge, **set wins**: a new producer has issued, so the bit stays 1.
  - Set and clear on different addresses on the same edge both take effect.
- `rbusy` port k = pend[`raddr` port k]. It reflects the registered pending bits only; a same-cycle `pset` is not visible.
- Reset, on a rising edge with `rst_n`=0:
  - all registers clear to 0 and all pending bits clear;
  - `we` and `pset` are ignored that edge.
  - Since `rdata`/`rbusy` are combinational, they read 0 from the cycle after that edge.
  - Reset asserted mid-sequence overrides any write or set in the same cycle.

## Timing
- Read latency is 0 cycles: combinational from `raddr` (and from `wdata`/`we` when bypass is compiled in).
- Write latency is 1 edge. Without bypass, a written value is visible on `rdata` in the cycle after the edge.
- Pending set/clear takes effect at the edge. `rbusy` updates in the following cycle.
- No handshake: every request is accepted every cycle.
- Outputs after reset:
  - `rdata` = 0 for every port;
  - `rbusy` = 0 for every port.

## Configuration
- Macro `RF_BYPASS_EN`.
- **Defined**: for each port k, if `we`=1 and `waddr`=`raddr` port k and `waddr`!=0, then in the same cycle:
  - `rdata` port k = `wdata`;
  - `rbusy` port k = 0, since the producer is completing now. This holds even if `pset` targets the same address that cycle.
- **Undefined**: read-during-write returns the old stored value and the current `rbusy`. The new value appears the next cycle.

## Test plan
1. Reset then read: hold `rst_n`=0 for 1 edge, release. Every `rdata` port = 0 and every `rbusy` = 0 at all addresses.
2. Write and read back on all ports:
   - Edge 1: write 1337 to r16.
   - Edge 2: write 69 to r9.
   - Then read port 0 = r16 and port 1 = r9 → 1337 and 69.
   - Write 0xDEADBEEF to r0 → r0 still reads 0.
3. Read-during-write: `we`=1, `waddr`=5, `wdata`=0xA5A5A5A5, `raddr` port 0 = 5, r5 previously 7.
   - With `RF_BYPASS_EN`: `rdata` port 0 = 0xA5A5A5A5 in the same cycle.
   - Without it: 7 in that cycle, 0xA5A5A5A5 the next.
4. Scoreboard:
   - `pset` on r12, then read r12 → `rbusy`=1 the next cycle.
   - Write r12 with 42 → `rbusy`=0 the cycle after and `rdata`=42.
   - `pset` with `paddr`=0 → `rbusy` stays 0.
5. Simultaneous set and clear:
   - r3 pending; same edge `pset` r3 and write r3 = 11 → pend[3] remains 1 and r3 = 11.
   - Same edge `pset` r4 and write r3 → pend[4]=1 and pend[3]=0.
6. Reset mid-operation:
   - r7 = 99 and pend[8]=1.
   - Assert `rst_n`=0 in the same cycle as a write of r7 = 5 → after the edge r7 = 0, pend[8]=0, and the write is lost.
   - Repeat with `NR`=3 and `DW`=16 to cover the parametrisation.
